// File: rtl/ft_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : ft_run_controller
// Purpose  : Temporal-redundancy run sequencer for a single zeroriscy_soc core.
//            Runs the same program two or three times, captures the result
//            word of each run and produces a 2-of-3 majority-voted result.
// Ports    : clk_i/rst_i      - clock, async active-high reset
//            start_i          - one-cycle job start (accepted in IDLE/DONE)
//            mem_flag_i       - core completion word (nonzero = finished)
//            mem_result_i     - core result word, sampled with completion
//            core_rst_no      - active-low reset to the core
//            fetch_en_o       - fetch enable to the core
//            busy_o/done_o    - job in progress / job finished (held)
//            error_o          - no majority (valid with done_o)
//            timeout_o        - some run in this job timed out (sticky)
//            result_o         - voted result (valid with done_o)
//            run_cnt_o        - runs completed in the current job
// Revision : 1.0 - initial release
// ============================================================================
module ft_run_controller #(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] mem_flag_i,
  input  logic [31:0] mem_result_i,
  output logic        core_rst_no,
  output logic        fetch_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        timeout_o,
  output logic [31:0] result_o,
  output logic [1:0]  run_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic [31:0]      r0, r1, r2;
  logic [2:0]       v;

  logic flag_nz;
  logic complete;
  logic agree01, agree02, agree12;

  assign flag_nz  = |mem_flag_i;
  // A flag is only trusted once it has been seen low inside this run, so a
  // completion word left over from the previous run cannot end the new one.
  assign complete = armed & flag_nz;
  assign agree01  = v[0] & v[1] & (r0 == r1);
  assign agree02  = v[0] & v[2] & (r0 == r2);
  assign agree12  = v[1] & v[2] & (r1 == r2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      r0          <= '0;
      r1          <= '0;
      r2          <= '0;
      v           <= '0;
      core_rst_no <= 1'b0;
      fetch_en_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      timeout_o   <= 1'b0;
      result_o    <= '0;
      run_cnt_o   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          core_rst_no <= 1'b0;
          fetch_en_o  <= 1'b0;
          if (start_i) begin
            state     <= S_HOLD;
            cnt       <= '0;
            v         <= '0;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
            timeout_o <= 1'b0;
            run_cnt_o <= '0;
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state       <= S_RUN;
            cnt         <= '0;
            armed       <= 1'b0;
            core_rst_no <= 1'b1;
            fetch_en_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          armed <= armed | ~flag_nz;
          cnt   <= cnt + 1'b1;
          // Completion has priority over a timeout in the same cycle.
          if (complete || (cnt == RUN_LAST)) begin
            state       <= S_CHECK;
            core_rst_no <= 1'b0;
            fetch_en_o  <= 1'b0;
            if (!complete) timeout_o <= 1'b1;
            case (run_cnt_o)
              2'd0: begin
                r0   <= mem_result_i;
                v[0] <= complete;
              end
              2'd1: begin
                r1   <= mem_result_i;
                v[1] <= complete;
              end
              default: begin
                r2   <= mem_result_i;
                v[2] <= complete;
              end
            endcase
          end
        end

        S_CHECK: begin
          cnt <= '0;
          if (run_cnt_o != 2'd3) run_cnt_o <= run_cnt_o + 1'b1;
          case (run_cnt_o)
            2'd0: state <= S_HOLD;
            2'd1: begin
              if (agree01) begin
                result_o <= r0;
                state    <= S_DONE;
                done_o   <= 1'b1;
                busy_o   <= 1'b0;
              end else begin
                state <= S_HOLD;
              end
            end
            default: begin
              if (agree02) begin
                result_o <= r0;
              end else if (agree12) begin
                result_o <= r1;
              end else if (agree01) begin
                result_o <= r0;
              end else begin
                result_o <= '0;
                error_o  <= 1'b1;
              end
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_run_controller
// Purpose  : Directed self-checking bench for ft_run_controller. Acts as the
//            core: watches fetch enable and raises the completion flag with a
//            result at a chosen RUN cycle (or never / stale).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_run_controller;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] mem_flag_i;
  logic [31:0] mem_result_i;
  logic        core_rst_no;
  logic        fetch_en_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        timeout_o;
  logic [31:0] result_o;
  logic [1:0]  run_cnt_o;

  int checks   = 0;
  int failures = 0;

  localparam int NEVER = 100000;

  ft_run_controller #(
    .RST_CYCLES    (4),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mem_flag_i  (mem_flag_i),
    .mem_result_i(mem_result_i),
    .core_rst_no (core_rst_no),
    .fetch_en_o  (fetch_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .timeout_o   (timeout_o),
    .result_o    (result_o),
    .run_cnt_o   (run_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Plays one run as the core. low_n = negedges seen with fetch disabled
  // before the run began; run_n = negedges seen with fetch enabled.
  task automatic do_run(input int flag_cyc, input logic [31:0] res, input bit stale,
                        output int low_n, output int run_n);
    low_n = 0;
    run_n = 0;
    while (!fetch_en_o && low_n < 500) begin
      low_n++;
      @(negedge clk);
    end
    chk("run_started", {31'd0, fetch_en_o}, 32'd1);
    chk("core_out_of_reset", {31'd0, core_rst_no}, 32'd1);
    while (fetch_en_o && run_n < 500) begin
      mem_flag_i   = stale ? 32'h1 : ((run_n >= flag_cyc) ? 32'h8000_0000 : 32'h0);
      mem_result_i = (run_n == flag_cyc) ? res : (32'hBAD0_0000 | run_n);
      run_n++;
      @(negedge clk);
    end
    mem_flag_i   = '0;
    mem_result_i = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    int lo, rn;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    mem_flag_i   = '0;
    mem_result_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst_no", {31'd0, core_rst_no}, 32'd0);
    chk("rst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_run_cnt", {30'd0, run_cnt_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // 1: two agreeing runs
    pulse_start();
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    do_run(20, 32'h2A, 1'b0, lo, rn);
    chk("t1_hold_len_run1", lo, 32'd4);
    chk("t1_run_len", rn, 32'd21);
    do_run(20, 32'h2A, 1'b0, lo, rn);
    chk("t1_gap_run2", lo, 32'd5);
    wait_done();
    chk("t1_result", result_o, 32'h2A);
    chk("t1_error", {31'd0, error_o}, 32'd0);
    chk("t1_timeout", {31'd0, timeout_o}, 32'd0);
    chk("t1_run_cnt", {30'd0, run_cnt_o}, 32'd2);
    chk("t1_busy_off", {31'd0, busy_o}, 32'd0);

    // 2: 5,7,5 -> majority 5
    pulse_start();
    chk("t2_done_cleared", {31'd0, done_o}, 32'd0);
    chk("t2_result_held", result_o, 32'h2A);
    do_run(3, 32'd5, 1'b0, lo, rn);
    do_run(10, 32'd7, 1'b0, lo, rn);
    chk("t2_no_done_after_2", {31'd0, done_o}, 32'd0);
    do_run(50, 32'd5, 1'b0, lo, rn);
    wait_done();
    chk("t2_result", result_o, 32'd5);
    chk("t2_error", {31'd0, error_o}, 32'd0);
    chk("t2_run_cnt", {30'd0, run_cnt_o}, 32'd3);

    // 3: 5,7,9 -> no majority
    pulse_start();
    do_run(4, 32'd5, 1'b0, lo, rn);
    do_run(4, 32'd7, 1'b0, lo, rn);
    do_run(4, 32'd9, 1'b0, lo, rn);
    wait_done();
    chk("t3_result", result_o, 32'd0);
    chk("t3_error", {31'd0, error_o}, 32'd1);
    chk("t3_run_cnt", {30'd0, run_cnt_o}, 32'd3);

    // 4: stale flag never drops -> all runs time out
    pulse_start();
    do_run(0, 32'h77, 1'b1, lo, rn);
    chk("t4_timeout_len", rn, 32'd100);
    chk("t4_timeout_sticky", {31'd0, timeout_o}, 32'd1);
    do_run(0, 32'h77, 1'b1, lo, rn);
    do_run(0, 32'h77, 1'b1, lo, rn);
    wait_done();
    chk("t4_error", {31'd0, error_o}, 32'd1);
    chk("t4_timeout", {31'd0, timeout_o}, 32'd1);
    chk("t4_run_cnt", {30'd0, run_cnt_o}, 32'd3);
    chk("t4_result", result_o, 32'd0);

    // 5: run 1 times out, runs 2 and 3 agree
    pulse_start();
    chk("t5_timeout_cleared", {31'd0, timeout_o}, 32'd0);
    do_run(NEVER, 32'h0, 1'b0, lo, rn);
    chk("t5_timeout_len", rn, 32'd100);
    do_run(7, 32'h11, 1'b0, lo, rn);
    do_run(9, 32'h11, 1'b0, lo, rn);
    wait_done();
    chk("t5_result", result_o, 32'h11);
    chk("t5_timeout", {31'd0, timeout_o}, 32'd1);
    chk("t5_error", {31'd0, error_o}, 32'd0);
    chk("t5_run_cnt", {30'd0, run_cnt_o}, 32'd3);

    // 6: async reset mid-run-2, then start ignored during HOLD
    pulse_start();
    do_run(6, 32'h3, 1'b0, lo, rn);
    lo = 0;
    while (!fetch_en_o && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("t6_in_run2", {31'd0, fetch_en_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_core_rst_no", {31'd0, core_rst_no}, 32'd0);
    chk("t6_rst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_rst_run_cnt", {30'd0, run_cnt_o}, 32'd0);
    chk("t6_rst_result", result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    pulse_start();
    pulse_start();
    chk("t6_hold_run_cnt", {30'd0, run_cnt_o}, 32'd0);
    chk("t6_hold_busy", {31'd0, busy_o}, 32'd1);
    do_run(12, 32'h99, 1'b0, lo, rn);
    chk("t6_hold_not_restarted", lo, 32'd3);
    do_run(12, 32'h99, 1'b0, lo, rn);
    wait_done();
    chk("t6_result", result_o, 32'h99);
    chk("t6_run_cnt", {30'd0, run_cnt_o}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
